div_seq: RTL and testbench

- Multi-cycle iterative radix-2 divider sequencer, placed beside the EX stage and started by EX when it decodes DIV/DIVU.
- Captures the operands, runs one restoring-division step per cycle, and applies sign correction for signed division.
- Presents {remainder, quotient} for the HI/LO write, with a ready handshake.
- Drives busy_o, which the pipeline controller uses as the EX stall request.

---
 rtl/div_seq_if.sv | 35 +++
 rtl/div_seq.sv | 152 +++++++++++++++
 tb/tb_div_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - EX-stage to divider handshake bundle
//
// Purpose: groups the operand, control and result signals between the EX
//          stage (master) and the iterative divider (slave).
// Signals:
//   signed_div_i  1        1 = DIV (signed), 0 = DIVU
//   opdata1_i     WIDTH    dividend
//   opdata2_i     WIDTH    divisor
//   start_i       1        level request, held until ready_o is seen
//   annul_i       1        abort current operation
//   result_o      2*WIDTH  {remainder (HI), quotient (LO)}
//   ready_o       1        result_o valid
//   busy_o        1        operation in progress (EX stall request)
interface div_seq_if #(
    parameter int WIDTH = 32
);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative radix-2 restoring divider sequencer for DIV/DIVU
//
// Purpose: captures operands on start, performs one restoring-division step
//          per cycle, sign-corrects signed results and holds
//          {remainder, quotient} until EX drops start_i.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  div_seq_if.slave (operands, start/annul, result/ready/busy)
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   dvd;      // dividend, quotient bits shift in at LSB
    logic [WIDTH-1:0]   dvs;      // divisor magnitude
    logic [WIDTH-1:0]   rem;      // partial remainder
    logic               sgn_op;
    logic               sgn1;
    logic               sgn2;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_nxt;
    logic [WIDTH-1:0]   dvd_nxt;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [WIDTH-1:0]   op1_abs;
    logic [WIDTH-1:0]   op2_abs;
    logic               last_iter;

    assign last_iter = (cnt == CW'(WIDTH - 1));

    // One restoring step: a set MSB on the WIDTH+1-bit difference is the
    // borrow, meaning the divisor did not fit and the old value is kept.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        dvd_nxt = {dvd[WIDTH-2:0], ~diff[WIDTH]};
        q_fix   = (sgn_op && (sgn1 ^ sgn2)) ? (~dvd_nxt + 1'b1) : dvd_nxt;
        r_fix   = (sgn_op && sgn1) ? (~rem_nxt + 1'b1) : rem_nxt;
    end

    // Magnitudes only for signed division; the most negative value wraps to
    // itself, which gives the defined overflow result.
    always_comb begin
        op1_abs = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ?
                  (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
        op2_abs = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ?
                  (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start_i && !bus.annul_i) begin
                    next_state = (bus.opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: next_state = bus.annul_i ? IDLE : END;
            ON: begin
                if (bus.annul_i) begin
                    next_state = IDLE;
                end else if (last_iter) begin
                    next_state = END;
                end
            end
            END: begin
                if (bus.annul_i || !bus.start_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            sgn_op   <= 1'b0;
            sgn1     <= 1'b0;
            sgn2     <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    result_q <= '0;
                    if (next_state == ON) begin
                        cnt    <= '0;
                        rem    <= '0;
                        dvd    <= op1_abs;
                        dvs    <= op2_abs;
                        sgn_op <= bus.signed_div_i;
                        sgn1   <= bus.opdata1_i[WIDTH-1];
                        sgn2   <= bus.opdata2_i[WIDTH-1];
                    end
                end
                BYZERO: result_q <= '0;
                ON: begin
                    if (bus.annul_i) begin
                        result_q <= '0;
                    end else begin
                        rem <= rem_nxt;
                        dvd <= dvd_nxt;
                        cnt <= cnt + 1'b1;
                        if (last_iter) begin
                            result_q <= {r_fix, q_fix};
                        end
                    end
                end
                END: begin
                    if (next_state == IDLE) begin
                        result_q <= '0;
                    end
                end
                default: result_q <= '0;
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = (state == END);
    assign bus.busy_o   = (state == BYZERO) || (state == ON);
endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed table-driven bench for div_seq
module tb_div_seq;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_seq_if #(.WIDTH(W)) bus ();

    div_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] er;
        int          el;
        int          eb;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start is raised after a falling edge, so it is sampled at the next
    // rising edge; latency is counted in rising edges from the raise.
    task automatic run_div(input string name, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] er,
                           input int el, input int eb, input int mut_at);
        int lat;
        int bc;
        lat = 0;
        bc  = 0;
        @(negedge clk);
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == mut_at) begin
                bus.opdata1_i = ~a;
                bus.opdata2_i = 32'h3;
                bus.signed_div_i = ~sg;
            end
            if (bus.busy_o) bc++;
            if (bus.ready_o) begin
                lat = k;
                break;
            end
        end
        check({name, " latency"}, 64'(lat), 64'(el));
        check({name, " busy_cycles"}, 64'(bc), 64'(eb));
        check({name, " result"}, bus.result_o, er);
        bus.start_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({name, " ready_drop"}, 64'(bus.ready_o), 64'd0);
        check({name, " result_drop"}, bus.result_o, 64'd0);
    endtask

    task automatic wait_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0] = '{"divu_100_7",  1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},               W + 1, W};
        vecs[1] = '{"div_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD},  W + 1, W};
        vecs[2] = '{"div_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  {32'h00000001, 32'hFFFFFFFD},  W + 1, W};
        vecs[3] = '{"div_ovf",     1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h0, 32'h80000000},         W + 1, W};
        vecs[4] = '{"divu_5_0",    1'b0, 32'd5,         32'd0,         64'd0,                         2,     1};
        vecs[5] = '{"divu_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,         {32'h0, 32'hFFFFFFFF},         W + 1, W};
        vecs[6] = '{"divu_big",    1'b0, 32'h80000000,  32'hFFFFFFFF,  {32'h80000000, 32'h0},         W + 1, W};
        vecs[7] = '{"div_m9_m4",   1'b1, 32'hFFFFFFF7,  32'hFFFFFFFC,  {32'hFFFFFFFF, 32'd2},         W + 1, W};
        vecs[8] = '{"div_s_0",     1'b1, 32'hFFFFFFF0,  32'd0,         64'd0,                         2,     1};

        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b1;
        bus.annul_i      = 1'b0;
        rst              = 1'b0;
        wait_edges(2);
        check("reset ready", 64'(bus.ready_o), 64'd0);
        check("reset busy", 64'(bus.busy_o), 64'd0);
        check("reset result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        rst = 1'b1;
        wait_edges(1);

        for (int i = 0; i < 9; i++) begin
            run_div(vecs[i].name, vecs[i].sg, vecs[i].a, vecs[i].b,
                    vecs[i].er, vecs[i].el, vecs[i].eb, 0);
        end

        // Annul in IDLE blocks a simultaneous start
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        bus.start_i = 1'b1;
        bus.annul_i = 1'b1;
        wait_edges(1);
        check("idle_annul busy", 64'(bus.busy_o), 64'd0);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;

        // Annul at iteration 10: capture edge plus 10 iteration edges
        @(negedge clk);
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd3;
        bus.start_i = 1'b1;
        wait_edges(11);
        check("annul busy_before", 64'(bus.busy_o), 64'd1);
        bus.annul_i = 1'b1;
        wait_edges(1);
        check("annul ready", 64'(bus.ready_o), 64'd0);
        check("annul busy", 64'(bus.busy_o), 64'd0);
        check("annul result", bus.result_o, 64'd0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        run_div("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, W + 1, W, 0);

        // Operand change while in ON
        run_div("op_change", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, W + 1, W, 5);

        // Hold start in END: result stays put
        @(negedge clk);
        bus.signed_div_i = 1'b1;
        bus.opdata1_i = 32'hFFFFFF9C;
        bus.opdata2_i = 32'd7;
        bus.start_i = 1'b1;
        wait_edges(W + 4);
        check("hold ready", 64'(bus.ready_o), 64'd1);
        check("hold result", bus.result_o, {32'hFFFFFFFE, 32'hFFFFFFF2});
        bus.annul_i = 1'b1;
        wait_edges(1);
        check("end_annul ready", 64'(bus.ready_o), 64'd0);
        check("end_annul result", bus.result_o, 64'd0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;

        // Reset mid-operation at iteration 20
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i = 32'd12345;
        bus.opdata2_i = 32'd10;
        bus.start_i = 1'b1;
        wait_edges(21);
        rst = 1'b0;
        wait_edges(1);
        check("midrst ready", 64'(bus.ready_o), 64'd0);
        check("midrst busy", 64'(bus.busy_o), 64'd0);
        check("midrst result", bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        rst = 1'b1;
        run_div("after_rst", 1'b0, 32'd12345, 32'd10, {32'd5, 32'd1234}, W + 1, W, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
